// File: rtl/fm_pkg.sv
// Shared types and constants for the FSK frame sequencer and its timer.
package fm_pkg;

  localparam int unsigned PHASE_WIDTH = 32;

  // NCO phase increments at a 50 MHz clock
  localparam logic [PHASE_WIDTH-1:0] INC_5M00 = 32'd429496730;
  localparam logic [PHASE_WIDTH-1:0] INC_5M05 = 32'd433791697;
  localparam logic [PHASE_WIDTH-1:0] INC_4M95 = 32'd425201762;
  localparam logic [PHASE_WIDTH-1:0] INC_10M  = 32'd858993459;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2,
    TAIL     = 2'd3
  } fsk_state_e;

endpackage

// File: rtl/fsk_frame_sequencer_if.sv
// Byte stream handshake into the FSK frame sequencer.
interface fsk_frame_sequencer_if;
  logic [7:0] byte_data_i;
  logic       byte_last_i;
  logic       byte_valid_i;
  logic       byte_ready_o;

  modport master (
    output byte_data_i,
    output byte_last_i,
    output byte_valid_i,
    input  byte_ready_o
  );

  modport slave (
    input  byte_data_i,
    input  byte_last_i,
    input  byte_valid_i,
    output byte_ready_o
  );
endinterface

// File: rtl/fsk_frame_sequencer_baud_timer.sv
// Bit-period counter: runs 0..BAUD_DIV-1, o_strobe marks the last cycle of a bit.
module baud_timer
  import fm_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 50000
) (
  input  logic clk,
  input  logic reset_i,
  input  logic i_restart,
  output logic o_strobe
);

  localparam int unsigned CNT_W = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  // Free-running bit counter, held at zero while restart is asserted
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_cnt <= '0;
    end else if (i_restart || (r_cnt == CNT_LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_strobe = (r_cnt == CNT_LAST);

endmodule

// File: rtl/fsk_frame_sequencer.sv
// Framed binary-FSK controller driving the TX NCO phase increment.
module fsk_frame_sequencer
#(
  parameter int unsigned PHASE_WIDTH   = fm_pkg::PHASE_WIDTH,
  parameter int unsigned BAUD_DIV      = 50000,
  parameter int unsigned PREAMBLE_BITS = 16,
  parameter int unsigned TAIL_BITS     = 8,
  parameter logic [PHASE_WIDTH-1:0] DEFAULT_CENTER = fm_pkg::INC_5M00,
  parameter logic [PHASE_WIDTH-1:0] DEFAULT_DEV    = 4294967
) (
  input  logic                   clk,
  input  logic                   reset_i,
  input  logic [PHASE_WIDTH-1:0] cfg_center_i,
  input  logic [PHASE_WIDTH-1:0] cfg_dev_i,
  input  logic                   cfg_load_i,
  fsk_frame_sequencer_if.slave   byte_if,
  input  logic                   abort_i,
  output logic [PHASE_WIDTH-1:0] phi_inc_o,
  output logic                   carrier_en_o,
  output logic                   bit_strobe_o,
  output logic                   busy_o,
  output logic                   underrun_o
);

  import fm_pkg::*;

  localparam int unsigned BITS_MAX_PT = (PREAMBLE_BITS > TAIL_BITS) ? PREAMBLE_BITS : TAIL_BITS;
  localparam int unsigned BITS_MAX    = (BITS_MAX_PT > 8) ? BITS_MAX_PT : 8;
  localparam int unsigned BIT_W       = $clog2(BITS_MAX);
  localparam logic [BIT_W-1:0] PRE_LAST  = BIT_W'(PREAMBLE_BITS - 1);
  localparam logic [BIT_W-1:0] TAIL_LAST = BIT_W'(TAIL_BITS - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(7);

  fsk_state_e             r_state;
  logic [PHASE_WIDTH-1:0] r_center;
  logic [PHASE_WIDTH-1:0] r_dev;
  logic                   r_buf_full;
  logic [7:0]             r_buf_data;
  logic                   r_buf_last;
  logic [6:0]             r_shift;     // remaining data bits, next bit in [0]
  logic                   r_cur_last;
  logic [BIT_W-1:0]       r_bit_cnt;
  logic                   r_abort_pend;
  logic [PHASE_WIDTH-1:0] r_phi;
  logic                   r_carrier;
  logic                   r_strobe;
  logic                   r_underrun;

  logic [PHASE_WIDTH-1:0] w_mark;
  logic [PHASE_WIDTH-1:0] w_space;
  logic                   w_accept;
  logic                   w_tc;
  logic                   w_end;
  logic                   w_abort;

  assign w_mark   = r_center + r_dev;
  assign w_space  = r_center - r_dev;
  assign w_accept = byte_if.byte_valid_i && !r_buf_full;
  assign w_end    = w_tc && (r_state != IDLE);
  assign w_abort  = r_abort_pend || abort_i;

  baud_timer #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud_timer (
    .clk       (clk),
    .reset_i   (reset_i),
    .i_restart (r_state == IDLE),
    .o_strobe  (w_tc)
  );

  // Frame FSM together with holding buffer, config registers and registered outputs
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_state      <= IDLE;
      r_center     <= DEFAULT_CENTER;
      r_dev        <= DEFAULT_DEV;
      r_buf_full   <= 1'b0;
      r_buf_data   <= '0;
      r_buf_last   <= 1'b0;
      r_shift      <= '0;
      r_cur_last   <= 1'b0;
      r_bit_cnt    <= '0;
      r_abort_pend <= 1'b0;
      r_phi        <= DEFAULT_CENTER;
      r_carrier    <= 1'b0;
      r_strobe     <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      if (w_accept) begin
        r_buf_full <= 1'b1;
        r_buf_data <= byte_if.byte_data_i;
        r_buf_last <= byte_if.byte_last_i;
      end
      case (r_state)
        IDLE: begin
          r_abort_pend <= 1'b0;
          r_phi        <= r_center;
          if (cfg_load_i) begin
            r_center <= cfg_center_i;
            r_dev    <= cfg_dev_i;
          end
          if (r_buf_full) begin
            r_state    <= PREAMBLE;
            r_phi      <= w_mark;
            r_carrier  <= 1'b1;
            r_strobe   <= 1'b1;
            r_underrun <= 1'b0;
            r_bit_cnt  <= '0;
          end
        end
        PREAMBLE, DATA: begin
          if (abort_i) r_abort_pend <= 1'b1;
          if (w_end) begin
            r_strobe <= 1'b1;
            if (w_abort) begin
              // Buffered byte is discarded, even one accepted on this very edge
              r_abort_pend <= 1'b0;
              r_buf_full   <= 1'b0;
              r_state      <= TAIL;
              r_bit_cnt    <= '0;
              r_phi        <= w_mark;
            end else if ((r_state == PREAMBLE) && (r_bit_cnt != PRE_LAST)) begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
              r_phi     <= r_bit_cnt[0] ? w_mark : w_space;
            end else if ((r_state == DATA) && (r_bit_cnt != DATA_LAST)) begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
              r_shift   <= {1'b0, r_shift[6:1]};
              r_phi     <= r_shift[0] ? w_mark : w_space;
            end else if ((r_state == PREAMBLE) || (!r_cur_last && r_buf_full)) begin
              r_state    <= DATA;
              r_shift    <= r_buf_data[7:1];
              r_cur_last <= r_buf_last;
              r_buf_full <= 1'b0;
              r_bit_cnt  <= '0;
              r_phi      <= r_buf_data[0] ? w_mark : w_space;
            end else begin
              if (!r_cur_last) r_underrun <= 1'b1;
              r_state   <= TAIL;
              r_bit_cnt <= '0;
              r_phi     <= w_mark;
            end
          end
        end
        TAIL: begin
          r_abort_pend <= 1'b0;
          if (w_end) begin
            if (r_bit_cnt == TAIL_LAST) begin
              r_state   <= IDLE;
              r_phi     <= r_center;
              r_carrier <= 1'b0;
              r_bit_cnt <= '0;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
              r_phi     <= w_mark;
              r_strobe  <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign byte_if.byte_ready_o = !r_buf_full;
  assign phi_inc_o    = r_phi;
  assign carrier_en_o = r_carrier;
  assign bit_strobe_o = r_strobe;
  assign busy_o       = (r_state != IDLE);
  assign underrun_o   = r_underrun;

endmodule

// File: tb/tb_fsk_frame_sequencer.sv
// Directed self-checking bench for fsk_frame_sequencer (BAUD_DIV=4, 2 preamble, 2 tail bits).
module tb_fsk_frame_sequencer;

  localparam logic [31:0] C_DEF = 32'd429496730;
  localparam logic [31:0] D_DEF = 32'd4294967;
  localparam logic [31:0] M_DEF = 32'd433791697;   // C_DEF + D_DEF
  localparam logic [31:0] S_DEF = 32'd425201763;   // C_DEF - D_DEF

  logic        clk = 1'b0;
  logic        reset_i;
  logic [31:0] cfg_center_i;
  logic [31:0] cfg_dev_i;
  logic        cfg_load_i;
  logic        abort_i;
  logic [31:0] phi_inc_o;
  logic        carrier_en_o;
  logic        bit_strobe_o;
  logic        busy_o;
  logic        underrun_o;

  int n_vec = 0;
  int n_err = 0;

  fsk_frame_sequencer_if bif ();

  fsk_frame_sequencer #(
    .BAUD_DIV      (4),
    .PREAMBLE_BITS (2),
    .TAIL_BITS     (2)
  ) dut (
    .clk          (clk),
    .reset_i      (reset_i),
    .cfg_center_i (cfg_center_i),
    .cfg_dev_i    (cfg_dev_i),
    .cfg_load_i   (cfg_load_i),
    .byte_if      (bif.slave),
    .abort_i      (abort_i),
    .phi_inc_o    (phi_inc_o),
    .carrier_en_o (carrier_en_o),
    .bit_strobe_o (bit_strobe_o),
    .busy_o       (busy_o),
    .underrun_o   (underrun_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one byte from a negedge; returns at the negedge after the handshake
  task automatic offer(input logic [7:0] d, input logic l, input int limit);
    bit ok = 1'b0;
    bif.byte_data_i  = d;
    bif.byte_last_i  = l;
    bif.byte_valid_i = 1'b1;
    for (int i = 0; i < limit && !ok; i++) begin
      if (bif.byte_ready_o === 1'b1) begin
        @(posedge clk);
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    @(negedge clk);
    bif.byte_valid_i = 1'b0;
    check("offer_accepted", 64'(ok), 64'd1);
  endtask

  task automatic wait_carrier(input string tag, input int limit);
    int n = 0;
    while (carrier_en_o !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_start"}, 64'(carrier_en_o), 64'd1);
  endtask

  // Walk a frame from its first on-air cycle; pat bit i is 1 for mark on bit i
  task automatic check_frame(input string tag, input int nbits, input logic [63:0] pat,
                             input logic [31:0] mk, input logic [31:0] sp,
                             input logic [31:0] ctr, input int ur_at);
    int k = 0;
    logic [63:0] sh;
    logic [31:0] e;
    while (carrier_en_o === 1'b1 && k < 400) begin
      if (k < nbits * 4) begin
        sh = pat >> (k / 4);
        e  = sh[0] ? mk : sp;
        check({tag, "_phi"},  64'(phi_inc_o), 64'(e));
        check({tag, "_strb"}, 64'(bit_strobe_o), 64'((k % 4) == 0));
        check({tag, "_busy"}, 64'(busy_o), 64'd1);
        check({tag, "_ur"},   64'(underrun_o), 64'((ur_at >= 0) && (k >= ur_at)));
      end
      k++;
      @(negedge clk);
    end
    check({tag, "_len"},       64'(k), 64'(nbits * 4));
    check({tag, "_idle_phi"},  64'(phi_inc_o), 64'(ctr));
    check({tag, "_idle_busy"}, 64'(busy_o), 64'd0);
  endtask

  initial begin
    reset_i          = 1'b1;
    cfg_center_i     = '0;
    cfg_dev_i        = '0;
    cfg_load_i       = 1'b0;
    abort_i          = 1'b0;
    bif.byte_data_i  = '0;
    bif.byte_last_i  = 1'b0;
    bif.byte_valid_i = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_phi",   64'(phi_inc_o), 64'(C_DEF));
    check("rst_car",   64'(carrier_en_o), 64'd0);
    check("rst_ready", 64'(bif.byte_ready_o), 64'd1);
    check("rst_busy",  64'(busy_o), 64'd0);
    check("rst_strb",  64'(bit_strobe_o), 64'd0);
    check("rst_ur",    64'(underrun_o), 64'd0);
    reset_i = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_phi",  64'(phi_inc_o), 64'(C_DEF));

    // Single byte 0xA5, last=1: 12 bits, 48 cycles
    offer(8'hA5, 1'b1, 50);
    check("a5_ready_low", 64'(bif.byte_ready_o), 64'd0);
    check("a5_car_T",     64'(carrier_en_o), 64'd0);
    wait_carrier("a5", 20);
    check_frame("a5", 12, 64'({2'b11, 8'hA5, 2'b01}), M_DEF, S_DEF, C_DEF, -1);

    // Two bytes 0x00 then 0xFF offered while the first is in flight: 20 bits, 80 cycles
    offer(8'h00, 1'b0, 50);
    fork
      offer(8'hFF, 1'b1, 200);
    join_none
    wait_carrier("two", 20);
    check_frame("two", 20, 64'({2'b11, 8'hFF, 8'h00, 2'b01}), M_DEF, S_DEF, C_DEF, -1);
    check("two_ready", 64'(bif.byte_ready_o), 64'd1);

    // Byte without last and nothing following: underrun at first tail cycle (k=40)
    offer(8'h3C, 1'b0, 50);
    wait_carrier("ur", 20);
    check_frame("ur", 12, 64'({2'b11, 8'h3C, 2'b01}), M_DEF, S_DEF, C_DEF, 40);
    check("ur_sticky", 64'(underrun_o), 64'd1);

    // Config load in IDLE with wrapping space; a load during DATA is ignored
    cfg_center_i = 32'h0000_0010;
    cfg_dev_i    = 32'h0000_0020;
    cfg_load_i   = 1'b1;
    @(negedge clk);
    cfg_load_i   = 1'b0;
    @(negedge clk);
    check("cfg_idle_phi", 64'(phi_inc_o), 64'h10);
    offer(8'h0F, 1'b1, 50);
    wait_carrier("cfg", 20);
    fork
      begin
        repeat (12) @(negedge clk);
        cfg_center_i = 32'h1234_5678;
        cfg_dev_i    = 32'h0000_0001;
        cfg_load_i   = 1'b1;
        @(negedge clk);
        cfg_load_i   = 1'b0;
      end
    join_none
    check_frame("cfg", 12, 64'({2'b11, 8'h0F, 2'b01}), 32'h30, 32'hFFFF_FFF0, 32'h10, -1);
    @(negedge clk);
    check("cfg_kept", 64'(phi_inc_o), 64'h10);

    // Restore default tones
    cfg_center_i = C_DEF;
    cfg_dev_i    = D_DEF;
    cfg_load_i   = 1'b1;
    @(negedge clk);
    cfg_load_i   = 1'b0;
    @(negedge clk);
    check("cfg_restore", 64'(phi_inc_o), 64'(C_DEF));

    // Abort mid-bit in data bit 2 with a second byte buffered: 7 bits, buffer flushed
    offer(8'h55, 1'b0, 50);
    fork
      offer(8'hAA, 1'b1, 200);
    join_none
    wait_carrier("abt", 20);
    fork
      begin
        repeat (17) @(negedge clk);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
      end
    join_none
    check_frame("abt", 7, 64'({2'b11, 3'b101, 2'b01}), M_DEF, S_DEF, C_DEF, -1);
    check("abt_ready", 64'(bif.byte_ready_o), 64'd1);
    repeat (10) @(negedge clk);
    check("abt_no_frame", 64'(carrier_en_o), 64'd0);
    check("abt_ur", 64'(underrun_o), 64'd0);

    // Asynchronous reset mid-frame
    offer(8'hA5, 1'b1, 50);
    wait_carrier("mrst", 20);
    repeat (10) @(negedge clk);
    check("mrst_pre_car", 64'(carrier_en_o), 64'd1);
    #2 reset_i = 1'b1;
    #1;
    check("mrst_phi",   64'(phi_inc_o), 64'(C_DEF));
    check("mrst_car",   64'(carrier_en_o), 64'd0);
    check("mrst_ready", 64'(bif.byte_ready_o), 64'd1);
    check("mrst_busy",  64'(busy_o), 64'd0);
    @(negedge clk);
    reset_i = 1'b0;
    repeat (3) @(negedge clk);
    check("mrst_stay_idle", 64'(carrier_en_o), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
